// File: rtl/blocking_swap.sv
// Two-flop reference cell with ordered (blocking-style) update: the second
// register is derived from the first register's newly computed value.
module blocking_swap (
  input  logic clk,
  input  logic rst_n,
  input  logic a_i,
  input  logic b_i,
  output logic a_o,
  output logic b_o
);

  logic a_q;
  logic b_q;
  logic a_nxt;
  logic b_nxt;

  // b_nxt chains off a_nxt, so both flops see the same edge's a_i.
  always_comb begin
    a_nxt = a_i;
    b_nxt = a_nxt ^ b_i;
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= a_nxt;
      b_q <= b_nxt;
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;

endmodule

// File: tb/tb_blocking_swap.sv
// Bench for blocking_swap: directed scenarios plus randomized traffic checked
// against an edge-by-edge reference model.
module tb_blocking_swap;

  logic clk = 1'b0;
  logic rst_n;
  logic a_i;
  logic b_i;
  logic a_o;
  logic b_o;

  int checks = 0;
  int failures = 0;

  // Reference state: what the pair should hold after the most recent edge.
  logic ref_a;
  logic ref_b;

  blocking_swap dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a_i  (a_i),
    .b_i  (b_i),
    .a_o  (a_o),
    .b_o  (b_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Outputs after an edge: cleared under reset, else a follows a_i and
  // b is that same new a combined with b_i.
  task automatic model_edge(input logic r, input logic a, input logic b);
    if (r) begin
      ref_a = 1'b0;
      ref_b = 1'b0;
    end else begin
      ref_a = a;
      ref_b = a ^ b;
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, compare.
  task automatic step(input string tag, input logic r, input logic a, input logic b);
    @(negedge clk);
    rst_n = r;
    a_i   = a;
    b_i   = b;
    @(posedge clk);
    model_edge(r, a, b);
    #1;
    check({tag, "_a"}, a_o, ref_a);
    check({tag, "_b"}, b_o, ref_b);
  endtask

  // Explicit-value check for directed scenarios written straight from the rules.
  task automatic step_exp(input string tag, input logic r, input logic a, input logic b,
                          input logic ea, input logic eb);
    step(tag, r, a, b);
    check({tag, "_a_lit"}, a_o, ea);
    check({tag, "_b_lit"}, b_o, eb);
  endtask

  initial begin
    rst_n = 1'b1;
    a_i   = 1'b1;
    b_i   = 1'b1;

    step_exp("rst0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step_exp("rst1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // First edge after release uses the new a, so b must be 1, not 0.
    step_exp("order", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    step_exp("xor0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step_exp("xor1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    step_exp("trk0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step_exp("trk1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step_exp("trk2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step_exp("trk3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-stream reset from a=1,b=1, then release.
    step_exp("pre_mrst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step_exp("mrst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step_exp("mrel", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Glitch on a_i strictly between edges must not be captured.
    step_exp("gl_base", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 a_i = 1'b1;
    #2 a_i = 1'b0;
    @(posedge clk);
    #1;
    check("glitch_e1_a", a_o, 1'b0);
    check("glitch_e1_b", b_o, 1'b0);
    step_exp("glitch_e2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
